// File: rtl/cs_measure_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs_pkg
// Brief    : Shared constants, state type and width helper for the
//            compressed-sensing measurement path (acquisition and
//            reconstruction sides).
// Revision : 1.0 - initial release
// ============================================================================
package cs_pkg;

  // Q3.13 unsigned sample format delivered by the input-conditioning stage
  localparam int FRAC_BITS = 13;
  localparam int D_W       = 16;

  // Galois LFSR polynomial and per-frame seed used to generate Phi
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Frame controller states
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Signed accumulator width that holds N * (2^d_w - 1) in either direction
  function automatic int acc_width(input int d_w, input int n);
    return d_w + 1 + $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cs_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : cs_lfsr16
// Brief    : 16-bit Galois LFSR with synchronous load and step. Shared by
//            the measurement and reconstruction sides to regenerate Phi.
// Revision : 1.0 - initial release
// ============================================================================
module cs_lfsr16
  import cs_pkg::*;
#(
  parameter logic [15:0] TAPS      = LFSR_TAPS,
  parameter logic [15:0] RESET_VAL = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_state;
  logic [15:0] w_next;

  // Galois step: shift right, fold the taps in when the outgoing bit is set
  assign w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : 16'h0000);

  // Load has priority so a frame restart always begins from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_VAL;
    end else if (load) begin
      r_state <= seed;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign q = r_state;

endmodule
`default_nettype wire

// File: rtl/cs_measure_accum.sv
`default_nettype none
// ============================================================================
// Module   : cs_measure_accum
// Brief    : Forms M compressed-sensing measurements y = Phi*x over frames
//            of N Q3.13 samples, with Phi a +/-1 Bernoulli matrix taken from
//            an LFSR, then drains them over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cs_measure_accum #(
  parameter int          N         = 64,
  parameter int          M         = 16,
  parameter int          D_W       = 16,
  parameter int          ACC_W     = cs_pkg::acc_width(D_W, N),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [D_W-1:0]          d_in,
  input  logic                    flag_in,
  output logic signed [ACC_W-1:0] m_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    drop_err
);

  import cs_pkg::*;

  localparam int C_IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int C_CNT_W = $clog2(N);

  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(M - 1);
  localparam logic [C_IDX_W-1:0] C_IDX_ONE  = C_IDX_W'(1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(N - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_IDX_W-1:0]   r_idx;
  logic                 r_valid;
  logic                 r_drop;

  logic [15:0]             w_lfsr;
  logic                    w_accept;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_final;
  logic signed [ACC_W-1:0] w_sample;
  logic signed [ACC_W-1:0] w_acc [M];

  assign w_accept = (r_state == ST_ACCUM) && en && flag_in;
  assign w_hs     = r_valid && m_ready;
  assign w_last   = (r_idx == C_LAST_IDX);
  assign w_final  = w_hs && w_last;

  // Unsigned sample widened with zeros so it is always a positive operand
  assign w_sample = $signed({{(ACC_W - D_W){1'b0}}, d_in});

  // Sign source: advances per accepted sample, reseeded when a frame ends
  cs_lfsr16 #(
    .TAPS      (LFSR_TAPS),
    .RESET_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_final),
    .step (w_accept),
    .seed (LFSR_SEED),
    .q    (w_lfsr)
  );

  // One signed accumulator per measurement row; LFSR bit j picks add/subtract
  for (genvar j = 0; j < M; j++) begin : g_acc
    logic signed [ACC_W-1:0] r_acc;

    // Clear at end of drain, otherwise fold in each accepted sample
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
      end else if (w_final) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= w_lfsr[j] ? (r_acc - w_sample) : (r_acc + w_sample);
      end
    end

    assign w_acc[j] = r_acc;
  end

  // Frame controller: count samples in ACCUM, walk the drain index in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (r_cnt == C_CNT_LAST) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_valid <= 1'b1;
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_state <= ST_ACCUM;
            end else begin
              r_idx <= r_idx + C_IDX_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  // Sticky record of any sample strobe that arrived while draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else if ((r_state == ST_DRAIN) && en && flag_in) begin
      r_drop <= 1'b1;
    end
  end

  // m_valid and busy share the register that marks the DRAIN phase
  assign m_valid  = r_valid;
  assign busy     = r_valid;
  assign m_last   = r_valid && w_last;
  assign m_out    = r_valid ? w_acc[r_idx] : '0;
  assign drop_err = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cs_measure_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_measure_accum
// Brief    : Self-checking bench for cs_measure_accum. A small instance
//            (N=2, M=4) and a full-size instance (N=64, M=16) share the
//            stimulus; sel steers strobes to one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_measure_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        flag;
  logic        m_ready;
  logic        sel;
  logic [15:0] d_in;

  logic s_flag, l_flag;
  logic signed [17:0] s_m_out;
  logic signed [22:0] l_m_out;
  logic s_valid, s_last, s_busy, s_drop;
  logic l_valid, l_last, l_busy, l_drop;

  assign s_flag = flag & ~sel;
  assign l_flag = flag & sel;

  cs_measure_accum #(.N(2), .M(4), .D_W(16), .LFSR_SEED(16'hACE1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .flag_in(s_flag),
    .m_out(s_m_out), .m_valid(s_valid), .m_ready(m_ready), .m_last(s_last),
    .busy(s_busy), .drop_err(s_drop)
  );

  cs_measure_accum #(.N(64), .M(16), .D_W(16), .LFSR_SEED(16'hACE1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .flag_in(l_flag),
    .m_out(l_m_out), .m_valid(l_valid), .m_ready(m_ready), .m_last(l_last),
    .busy(l_busy), .drop_err(l_drop)
  );

  logic signed [22:0] o_out;
  logic o_valid, o_last, o_busy, o_drop;
  assign o_out   = sel ? l_m_out : {{5{s_m_out[17]}}, s_m_out};
  assign o_valid = sel ? l_valid : s_valid;
  assign o_last  = sel ? l_last  : s_last;
  assign o_busy  = sel ? l_busy  : s_busy;
  assign o_drop  = sel ? l_drop  : s_drop;

  int total = 0;
  int bad   = 0;

  longint exp_m [16];
  int     smp   [64];
  bit     exp_drop [2];

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // mode: 0 random data/idles/ready, 1 golden 0x0440, 2 all 0xFFFF
  // Called and returns at a negative clock edge.
  task automatic do_frame(input int mode, input int stall, input bit drop_pulse,
                          input bit rst_mid);
    int n, m, k, cyc, stall_left, idle;
    logic [15:0] st;
    n = sel ? 64 : 2;
    m = sel ? 16 : 4;

    // Reference: y_j = sum_k (+/-) x_k, sign from bit j of the k-th LFSR state
    for (int i = 0; i < n; i++)
      smp[i] = (mode == 0) ? int'($urandom_range(0, 65535)) : (mode == 1) ? 1088 : 65535;
    for (int j = 0; j < 16; j++) exp_m[j] = 0;
    st = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < m; j++)
        exp_m[j] = st[j] ? exp_m[j] - smp[i] : exp_m[j] + smp[i];
      st = lfsr_next(st);
    end

    // Feed samples, with ignored idle cycles (en low or no strobe) in random mode
    for (int i = 0; i < n; i++) begin
      if (mode == 0) begin
        idle = $urandom_range(0, 2);
        repeat (idle) begin
          en      = 1'($urandom_range(0, 1));
          flag    = en ? 1'b0 : 1'($urandom_range(0, 1));
          d_in    = 16'($urandom);
          m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      check("pre_valid", o_valid, 0);
      en = 1'b1; flag = 1'b1; d_in = 16'(smp[i]);
      @(negedge clk);
    end
    en = 1'b0; flag = 1'b0; m_ready = 1'b0;

    // Drain and compare each measurement, including while stalled
    k = 0; cyc = 0; stall_left = stall;
    while (k < m && cyc < 300) begin
      check("valid", o_valid, 1);
      check("busy", o_busy, 1);
      check($sformatf("m_out[%0d]", k), longint'(o_out), exp_m[k]);
      check("m_last", o_last, (k == m - 1) ? 1 : 0);
      if (rst_mid && k == 2) begin
        rst = 1'b1;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_last", o_last, 0);
        check("rst_mout", longint'(o_out), 0);
        check("rst_drop", o_drop, 0);
        exp_drop[0] = 1'b0; exp_drop[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (mode == 0) begin
        m_ready = ($urandom_range(0, 3) != 0);
      end else begin
        m_ready = 1'b1;
      end
      if (drop_pulse && (k == 1 || k == m - 1)) begin
        en = 1'b1; flag = 1'b1; d_in = 16'hFFFF;
        exp_drop[sel] = 1'b1;
      end
      @(posedge clk);
      if (m_ready) k++;
      @(negedge clk);
      en = 1'b0; flag = 1'b0;
      cyc++;
    end
    check("drain_timeout", (cyc < 300) ? 1 : 0, 1);
    check("post_valid", o_valid, 0);
    check("post_busy", o_busy, 0);
    check("post_last", o_last, 0);
    check("drop_err", o_drop, exp_drop[sel]);
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flag = 1'b0; d_in = '0; m_ready = 1'b0; sel = 1'b0;
    exp_drop[0] = 1'b0; exp_drop[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check("reset_valid", o_valid, 0);
      check("reset_busy", o_busy, 0);
      check("reset_last", o_last, 0);
      check("reset_mout", longint'(o_out), 0);
      check("reset_drop", o_drop, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    @(negedge clk);

    do_frame(1, 0, 1'b0, 1'b0);   // golden
    do_frame(1, 5, 1'b0, 1'b0);   // backpressure
    do_frame(1, 0, 1'b0, 1'b0);   // back-to-back repeats
    do_frame(1, 0, 1'b0, 1'b0);
    do_frame(1, 0, 1'b1, 1'b0);   // drop during drain and on final handshake
    do_frame(1, 0, 1'b0, 1'b0);   // next frame unaffected
    repeat (8) do_frame(0, $urandom_range(0, 3), 1'b0, 1'b0);
    do_frame(1, 0, 1'b0, 1'b1);   // reset after two handshakes
    do_frame(1, 0, 1'b0, 1'b0);   // golden again after reset

    sel = 1'b1;
    @(negedge clk);
    do_frame(2, 0, 1'b0, 1'b0);   // extremes
    repeat (3) do_frame(0, $urandom_range(0, 3), 1'b0, 1'b0);
    do_frame(2, 2, 1'b1, 1'b0);
    do_frame(2, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
